// File: rtl/cdc_pkt_pkg.sv
// rtl/cdc_pkt_pkg.sv - shared state type and widths for the receive-side packet delineator
package cdc_pkt_pkg;

    typedef enum logic [1:0] {
        DLN_IDLE_S,
        DLN_RX_S,
        DLN_GAP_S
    } dln_state_e;

    localparam int CHK_W           = 16;
    localparam int LEN_W           = 8;
    localparam int DEF_FRAME_BYTES = 42;

endpackage

// File: rtl/cdc_sat_counter.sv
// rtl/cdc_sat_counter.sv - event counter that holds at all-ones
module cdc_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_b,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_b) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cdc_pkt_delineator.sv
// rtl/cdc_pkt_delineator.sv - fixed-length frame delineator with length/checksum status and good/bad counters
// Optional checksum compare against EXP_CHK is built only when CDC_PKT_DELIN_CHK_EN is defined.
module cdc_pkt_delineator
    import cdc_pkt_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int FRAME_BYTES = DEF_FRAME_BYTES,
    parameter int GAP_CYCLES  = 4,
    parameter int CNT_W       = 16
`ifdef CDC_PKT_DELIN_CHK_EN
    ,
    parameter logic [CHK_W-1:0] EXP_CHK = 16'h0387
`endif
) (
    input  logic             clk_b,
    input  logic             rst,
    input  logic             data_valid_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sof,
    output logic             out_eof,
    output logic             frame_done,
    output logic             frame_len_ok,
    output logic [LEN_W-1:0] frame_len,
    output logic [CHK_W-1:0] frame_chk,
    output logic             chk_err,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    localparam int               GAP_W     = $clog2(GAP_CYCLES + 1);
    localparam logic [LEN_W-1:0] FRAME_LEN = LEN_W'(FRAME_BYTES);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(GAP_CYCLES);

    dln_state_e       state_q, state_d;
    logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [CHK_W-1:0] chk_q, chk_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_sof_q, out_sof_d;
    logic             out_eof_q, out_eof_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_len_ok_q, frame_len_ok_d;
    logic [LEN_W-1:0] frame_len_q, frame_len_d;
    logic [CHK_W-1:0] frame_chk_q, frame_chk_d;
    logic             chk_err_q, chk_err_d;

    logic [LEN_W-1:0] cnt_inc;
    logic [CHK_W-1:0] chk_inc;
    logic [GAP_W-1:0] gap_inc;
    logic             good_inc;
    logic             bad_inc;

    always_comb begin
        // A byte seen in IDLE opens a frame, so count and sum restart from it.
        cnt_inc = (state_q == DLN_IDLE_S) ? LEN_W'(1) : byte_cnt_q + LEN_W'(1);
        chk_inc = ((state_q == DLN_IDLE_S) ? '0 : chk_q) + CHK_W'(data_b);
        gap_inc = (state_q == DLN_GAP_S) ? gap_cnt_q + GAP_W'(1) : GAP_W'(1);

        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        chk_d          = chk_q;
        out_valid_d    = data_valid_b;
        out_data_d     = data_b;
        out_sof_d      = 1'b0;
        out_eof_d      = 1'b0;
        frame_done_d   = 1'b0;
        frame_len_ok_d = 1'b0;
        frame_len_d    = '0;
        frame_chk_d    = '0;

        if (data_valid_b) begin
            out_sof_d  = (state_q == DLN_IDLE_S);
            byte_cnt_d = cnt_inc;
            chk_d      = chk_inc;
            gap_cnt_d  = '0;
            state_d    = DLN_RX_S;
            if (cnt_inc == FRAME_LEN) begin
                out_eof_d      = 1'b1;
                frame_done_d   = 1'b1;
                frame_len_ok_d = 1'b1;
                frame_len_d    = cnt_inc;
                frame_chk_d    = chk_inc;
                state_d        = DLN_IDLE_S;
                byte_cnt_d     = '0;
                chk_d          = '0;
            end
        end else if (state_q != DLN_IDLE_S) begin
            gap_cnt_d = gap_inc;
            state_d   = DLN_GAP_S;
            if (gap_inc == GAP_LIMIT) begin
                frame_done_d = 1'b1;
                frame_len_d  = byte_cnt_q;
                frame_chk_d  = chk_q;
                state_d      = DLN_IDLE_S;
                byte_cnt_d   = '0;
                gap_cnt_d    = '0;
                chk_d        = '0;
            end
        end

`ifdef CDC_PKT_DELIN_CHK_EN
        chk_err_d = frame_done_d && (frame_chk_d != EXP_CHK);
`else
        chk_err_d = 1'b0;
`endif
        good_inc = frame_done_d && frame_len_ok_d && !chk_err_d;
        bad_inc  = frame_done_d && !good_inc;
    end

    always_ff @(posedge clk_b) begin
        if (rst) begin
            state_q        <= DLN_IDLE_S;
            byte_cnt_q     <= '0;
            gap_cnt_q      <= '0;
            chk_q          <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_sof_q      <= 1'b0;
            out_eof_q      <= 1'b0;
            frame_done_q   <= 1'b0;
            frame_len_ok_q <= 1'b0;
            frame_len_q    <= '0;
            frame_chk_q    <= '0;
            chk_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            chk_q          <= chk_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_sof_q      <= out_sof_d;
            out_eof_q      <= out_eof_d;
            frame_done_q   <= frame_done_d;
            frame_len_ok_q <= frame_len_ok_d;
            frame_len_q    <= frame_len_d;
            frame_chk_q    <= frame_chk_d;
            chk_err_q      <= chk_err_d;
        end
    end

    // Counters step on the same edge that presents frame_done.
    cdc_sat_counter #(.CNT_W(CNT_W)) u_good_cnt (
        .clk_b (clk_b),
        .rst   (rst),
        .inc   (good_inc),
        .count (good_cnt)
    );

    cdc_sat_counter #(.CNT_W(CNT_W)) u_bad_cnt (
        .clk_b (clk_b),
        .rst   (rst),
        .inc   (bad_inc),
        .count (bad_cnt)
    );

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_sof      = out_sof_q;
    assign out_eof      = out_eof_q;
    assign frame_done   = frame_done_q;
    assign frame_len_ok = frame_len_ok_q;
    assign frame_len    = frame_len_q;
    assign frame_chk    = frame_chk_q;
    assign chk_err      = chk_err_q;

endmodule

// File: tb/tb_cdc_pkt_delineator.sv
// tb/tb_cdc_pkt_delineator.sv - randomized self-checking bench for cdc_pkt_delineator
module tb_cdc_pkt_delineator;

    localparam int FB  = 42;
    localparam int GAP = 4;
`ifdef CDC_PKT_DELIN_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk_b = 1'b0;
    logic        rst;
    logic        data_valid_b;
    logic [7:0]  data_b;

    logic        out_valid, out_sof, out_eof, frame_done, frame_len_ok, chk_err;
    logic [7:0]  out_data, frame_len;
    logic [15:0] frame_chk, good_cnt, bad_cnt;

    logic        s_out_valid, s_out_sof, s_out_eof, s_frame_done, s_frame_len_ok, s_chk_err;
    logic [7:0]  s_out_data, s_frame_len;
    logic [15:0] s_frame_chk;
    logic [1:0]  s_good_cnt, s_bad_cnt;

    cdc_pkt_delineator dut (
        .clk_b(clk_b), .rst(rst), .data_valid_b(data_valid_b), .data_b(data_b),
        .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
        .frame_done(frame_done), .frame_len_ok(frame_len_ok), .frame_len(frame_len),
        .frame_chk(frame_chk), .chk_err(chk_err), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    cdc_pkt_delineator #(.CNT_W(2)) dut_s (
        .clk_b(clk_b), .rst(rst), .data_valid_b(data_valid_b), .data_b(data_b),
        .out_valid(s_out_valid), .out_data(s_out_data), .out_sof(s_out_sof), .out_eof(s_out_eof),
        .frame_done(s_frame_done), .frame_len_ok(s_frame_len_ok), .frame_len(s_frame_len),
        .frame_chk(s_frame_chk), .chk_err(s_chk_err), .good_cnt(s_good_cnt), .bad_cnt(s_bad_cnt)
    );

`ifdef CDC_PKT_DELIN_CHK_EN
    logic        x_out_valid, x_out_sof, x_out_eof, x_frame_done, x_frame_len_ok, x_chk_err;
    logic [7:0]  x_out_data, x_frame_len;
    logic [15:0] x_frame_chk, x_good_cnt, x_bad_cnt;

    cdc_pkt_delineator #(.EXP_CHK(16'h0000)) dut_x (
        .clk_b(clk_b), .rst(rst), .data_valid_b(data_valid_b), .data_b(data_b),
        .out_valid(x_out_valid), .out_data(x_out_data), .out_sof(x_out_sof), .out_eof(x_out_eof),
        .frame_done(x_frame_done), .frame_len_ok(x_frame_len_ok), .frame_len(x_frame_len),
        .frame_chk(x_frame_chk), .chk_err(x_chk_err), .good_cnt(x_good_cnt), .bad_cnt(x_bad_cnt)
    );
`endif

    initial forever #5 clk_b = ~clk_b;

    // Reference model: the open frame is a byte queue, runts are detected by counting idle cycles.
    logic [7:0]  cur[$];
    int          idle_run;
    int          m_good, m_bad, x_good, x_bad;
    logic        e_valid, e_sof, e_eof, e_done, e_ok, e_err, e_xerr;
    logic [7:0]  e_data, e_len;
    logic [15:0] e_chk;
    int          passed, total;

    function automatic logic [1:0] sat2(input int n);
        return (n > 3) ? 2'd3 : 2'(n);
    endfunction

    task automatic close_frame(input logic ok);
        int sum = 0;
        foreach (cur[k]) sum += int'(cur[k]);
        e_done = 1'b1;
        e_ok   = ok;
        e_len  = 8'(cur.size());
        e_chk  = 16'(sum);
        e_err  = CHK_EN && (e_chk != 16'h0387);
        e_xerr = CHK_EN && (e_chk != 16'h0000);
        if (ok && !e_err) m_good++; else m_bad++;
        if (ok && !e_xerr) x_good++; else x_bad++;
        cur.delete();
        idle_run = 0;
    endtask

    // s = {rst, valid, data}; drives one cycle, then updates the model expectations.
    task automatic drive_cycle(input logic [9:0] s);
        rst          = s[9];
        data_valid_b = s[8];
        data_b       = s[7:0];
        @(posedge clk_b);
        #1;
        {e_valid, e_sof, e_eof, e_done, e_ok, e_err, e_xerr} = '0;
        e_data = '0; e_len = '0; e_chk = '0;
        if (s[9]) begin
            cur.delete();
            idle_run = 0;
            m_good = 0; m_bad = 0; x_good = 0; x_bad = 0;
        end else begin
            e_valid = s[8];
            e_data  = s[7:0];
            if (s[8]) begin
                e_sof = (cur.size() == 0);
                cur.push_back(s[7:0]);
                idle_run = 0;
                if (cur.size() == FB) begin
                    e_eof = 1'b1;
                    close_frame(1'b1);
                end
            end else if (cur.size() != 0) begin
                idle_run++;
                if (idle_run == GAP) close_frame(1'b0);
            end
        end
    endtask

    function automatic logic [127:0] exp_vec();
        logic [127:0] v = '0;
        v[11:0] = {e_valid, e_data, e_sof, e_eof, e_done};
        if (e_done) v[37:12] = {e_ok, e_len, e_chk, e_err};
        v[73:38] = {16'(m_good), 16'(m_bad), sat2(m_good), sat2(m_bad)};
`ifdef CDC_PKT_DELIN_CHK_EN
        if (e_done) v[74] = e_xerr;
        v[106:75] = {16'(x_good), 16'(x_bad)};
`endif
        return v;
    endfunction

    function automatic logic [127:0] obs_vec();
        logic [127:0] v = '0;
        v[11:0] = {out_valid, out_data, out_sof, out_eof, frame_done};
        if (e_done) v[37:12] = {frame_len_ok, frame_len, frame_chk, chk_err};
        v[73:38] = {good_cnt, bad_cnt, s_good_cnt, s_bad_cnt};
`ifdef CDC_PKT_DELIN_CHK_EN
        if (e_done) v[74] = x_chk_err;
        v[106:75] = {x_good_cnt, x_bad_cnt};
`endif
        return v;
    endfunction

    task automatic test_reset();
        logic [67:0] all_out;
        drive_cycle({1'b1, 1'b0, 8'h00});
        drive_cycle({1'b1, 1'b1, 8'h5a});
        all_out = {out_valid, out_data, out_sof, out_eof, frame_done, frame_len_ok,
                   frame_len, frame_chk, chk_err, good_cnt, bad_cnt};
        total++;
        if (all_out !== '0) $display("FAIL reset_outputs: got %h want 0", all_out);
        else passed++;
        total++;
        if ({s_good_cnt, s_bad_cnt} !== 4'd0) $display("FAIL reset_small_cnt: got %h want 0", {s_good_cnt, s_bad_cnt});
        else passed++;
    endtask

    task automatic test_contiguous();
        drive_cycle({1'b1, 9'h0});
        for (int i = 1; i <= FB; i++) begin
            drive_cycle({1'b0, 1'b1, 8'(i)});
            total++;
            if (obs_vec() !== exp_vec()) $display("FAIL contiguous_cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
            else passed++;
            if (i == 1) begin
                total++;
                if (out_sof !== 1'b1 || out_data !== 8'h01) $display("FAIL contiguous_sof: sof=%b data=%h want 1/01", out_sof, out_data);
                else passed++;
            end
        end
        total++;
        if (out_eof !== 1'b1 || out_data !== 8'h2a || frame_done !== 1'b1 || frame_len !== 8'd42 ||
            frame_len_ok !== 1'b1 || frame_chk !== 16'h0387 || good_cnt !== 16'd1 || bad_cnt !== 16'd0)
            $display("FAIL contiguous_eof: eof=%b data=%h done=%b len=%0d ok=%b chk=%h good=%0d bad=%0d want 1/2a/1/42/1/0387/1/0",
                     out_eof, out_data, frame_done, frame_len, frame_len_ok, frame_chk, good_cnt, bad_cnt);
        else passed++;
    endtask

    task automatic test_short_gap();
        logic [9:0] st[$];
        int dones = 0;
        drive_cycle({1'b1, 9'h0});
        for (int i = 1; i <= 20; i++) st.push_back({2'b01, 8'(i)});
        for (int i = 0; i < 3; i++) st.push_back(10'h000);
        for (int i = 21; i <= FB; i++) st.push_back({2'b01, 8'(i)});
        foreach (st[i]) begin
            drive_cycle(st[i]);
            if (frame_done === 1'b1) dones++;
            total++;
            if (obs_vec() !== exp_vec()) $display("FAIL short_gap_cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
            else passed++;
        end
        total++;
        if (dones != 1 || frame_done !== 1'b1 || frame_len !== 8'd42 || frame_chk !== 16'h0387 || good_cnt !== 16'd1)
            $display("FAIL short_gap_end: dones=%0d done=%b len=%0d chk=%h good=%0d want 1/1/42/0387/1",
                     dones, frame_done, frame_len, frame_chk, good_cnt);
        else passed++;
    endtask

    task automatic test_runt();
        logic [9:0] st[$];
        int done_at = -1;
        logic [7:0] g_len = 0;
        logic [15:0] g_chk = 0;
        logic g_ok = 1, g_eof = 1;
        drive_cycle({1'b1, 9'h0});
        for (int i = 1; i <= 20; i++) st.push_back({2'b01, 8'(i)});
        for (int i = 0; i < 6; i++) st.push_back(10'h000);
        foreach (st[i]) begin
            drive_cycle(st[i]);
            if (frame_done === 1'b1 && done_at < 0) begin
                done_at = i; g_len = frame_len; g_chk = frame_chk; g_ok = frame_len_ok; g_eof = out_eof;
            end
            total++;
            if (obs_vec() !== exp_vec()) $display("FAIL runt_cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
            else passed++;
        end
        total++;
        if (done_at != 23 || g_len !== 8'd20 || g_ok !== 1'b0 || g_chk !== 16'h00d2 || g_eof !== 1'b0 ||
            bad_cnt !== 16'd1 || good_cnt !== 16'd0)
            $display("FAIL runt_status: at=%0d len=%0d ok=%b chk=%h eof=%b bad=%0d good=%0d want 23/20/0/00d2/0/1/0",
                     done_at, g_len, g_ok, g_chk, g_eof, bad_cnt, good_cnt);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int eof_at = -1, sof2_at = -1, dones = 0;
        drive_cycle({1'b1, 9'h0});
        for (int i = 0; i < 2 * FB; i++) begin
            drive_cycle({2'b01, (i < FB) ? 8'(i + 1) : 8'($urandom_range(0, 255))});
            if (out_eof === 1'b1 && eof_at < 0) eof_at = i;
            if (out_sof === 1'b1 && i > 0 && sof2_at < 0) sof2_at = i;
            if (frame_done === 1'b1) dones++;
            total++;
            if (obs_vec() !== exp_vec()) $display("FAIL b2b_cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
            else passed++;
        end
        total++;
        if (eof_at != FB - 1 || sof2_at != FB || dones != 2 || good_cnt !== 16'd2)
            $display("FAIL b2b_status: eof=%0d sof=%0d dones=%0d good=%0d want 41/42/2/2", eof_at, sof2_at, dones, good_cnt);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [67:0] all_out;
        int dones = 0;
        drive_cycle({1'b1, 9'h0});
        for (int i = 1; i <= 9; i++) drive_cycle({2'b01, 8'(i)});
        drive_cycle({2'b11, 8'd10});
        all_out = {out_valid, out_data, out_sof, out_eof, frame_done, frame_len_ok,
                   frame_len, frame_chk, chk_err, good_cnt, bad_cnt};
        total++;
        if (all_out !== '0) $display("FAIL reset_mid_outputs: got %h want 0", all_out);
        else passed++;
        for (int i = 0; i < FB + GAP + 2; i++) begin
            drive_cycle((i < FB) ? {2'b01, 8'($urandom_range(0, 255))} : 10'h000);
            if (frame_done === 1'b1) dones++;
            total++;
            if (obs_vec() !== exp_vec()) $display("FAIL reset_mid_cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
            else passed++;
        end
        total++;
        if (dones != 1 || good_cnt !== 16'd1 || bad_cnt !== 16'd0)
            $display("FAIL reset_mid_status: dones=%0d good=%0d bad=%0d want 1/1/0", dones, good_cnt, bad_cnt);
        else passed++;
    endtask

    task automatic test_saturate();
        logic [1:0] want[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        drive_cycle({1'b1, 9'h0});
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < FB; i++) begin
                drive_cycle({2'b01, 8'($urandom_range(0, 255))});
                total++;
                if (obs_vec() !== exp_vec()) $display("FAIL saturate_f%0d_cyc%0d: got %h want %h", f, i, obs_vec(), exp_vec());
                else passed++;
            end
            total++;
            if (s_good_cnt !== want[f]) $display("FAIL saturate_good_f%0d: got %0d want %0d", f, s_good_cnt, want[f]);
            else passed++;
`ifdef CDC_PKT_DELIN_CHK_EN
            if (f == 0) begin
                total++;
                if (x_chk_err !== 1'b1 || x_bad_cnt !== 16'd1 || x_good_cnt !== 16'd0)
                    $display("FAIL chk_mismatch: err=%b bad=%0d good=%0d want 1/1/0", x_chk_err, x_bad_cnt, x_good_cnt);
                else passed++;
            end
`endif
        end
    endtask

    task automatic test_random();
        int burst = 0;
        drive_cycle({1'b1, 9'h0});
        for (int i = 0; i < 1500; i++) begin
            logic r, v;
            if (burst == 0 && $urandom_range(0, 24) == 0) burst = $urandom_range(1, 6);
            v = (burst == 0);
            if (burst > 0) burst--;
            r = ($urandom_range(0, 399) == 0);
            drive_cycle({r, v, 8'($urandom_range(0, 255))});
            total++;
            if (obs_vec() !== exp_vec()) $display("FAIL random_cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
            else passed++;
        end
    endtask

    initial begin
        passed = 0; total = 0;
        rst = 1'b1; data_valid_b = 1'b0; data_b = 8'h00;
        cur.delete(); idle_run = 0;
        m_good = 0; m_bad = 0; x_good = 0; x_bad = 0;
        test_reset();
        test_contiguous();
        test_short_gap();
        test_runt();
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cdc_pkt_delineator.md
Name: cdc_pkt_delineator

Overview:
- Receive-side stage in the clk_b domain, directly downstream of cdc_noip.
- Consumes the synchronized byte stream (data_valid_b/data_b).
- Splits the stream into fixed-length frames (42-byte IPv4 ARP requests by default) and marks start and end of each frame.
- Reports per-frame length status and a 16-bit byte-sum checksum, and keeps saturating good/bad frame counters, so CDC integrity is checked in hardware instead of by offline hex-dump comparison.

Parameters:
- WIDTH, 8, data byte width.
- FRAME_BYTES, 42, bytes per complete frame; range 1..255.
- GAP_CYCLES, 4, consecutive valid-low cycles inside a frame that abort it as a runt; minimum 1.
- CNT_W, 16, width of the good/bad frame counters.
- EXP_CHK, 16'h0387, expected checksum; used only with the optional feature.

Ports:
- clk_b  in  1  single clock (receive domain).
- rst  in  1  reset; synchronous, active-high.
- data_valid_b  in  1  byte qualifier from cdc_noip.
- data_b  in  WIDTH  byte from cdc_noip.
- out_valid  out  1  registered copy of data_valid_b.
- out_data  out  WIDTH  registered copy of data_b.
- out_sof  out  1  high with the first byte of a frame.
- out_eof  out  1  high with byte FRAME_BYTES of a frame.
- frame_done  out  1  one-cycle pulse when a frame ends (complete or runt).
- frame_len_ok  out  1  valid with frame_done; 1 when length == FRAME_BYTES.
- frame_len  out  8  byte count of the ended frame; valid with frame_done.
- frame_chk  out  16  sum of the frame's bytes mod 2^16; valid with frame_done.
- chk_err  out  1  valid with frame_done; checksum mismatch flag.
- good_cnt  out  CNT_W  count of good frames; saturates at all-ones.
- bad_cnt  out  CNT_W  count of bad frames; saturates at all-ones.

Behaviour:
- Reset (synchronous, clk_b edge with rst=1): all outputs 0, state IDLE, byte_cnt=0, gap_cnt=0, chk accumulator=0.
- Reset mid-frame: the partial frame is discarded; no frame_done is issued.
- Latency: every output is registered. out_* and frame_done appear exactly 1 clk_b cycle after the input byte or event that causes them.
- No backpressure: a byte is accepted on every cycle with data_valid_b=1.
- State IDLE:
  - valid=1 → out_sof=1, byte_cnt=1, chk=byte, go to RX.
  - If FRAME_BYTES==1, the same byte is also EOF: frame completes immediately and the state stays IDLE.
- State RX:
  - valid=1 → byte_cnt+1, chk+=byte.
  - When byte_cnt reaches FRAME_BYTES: out_eof=1, frame_done=1, frame_len_ok=1, frame_len=FRAME_BYTES, frame_chk=final sum; go to IDLE.
  - valid=0 → gap_cnt=1, go to GAP.
- State GAP:
  - valid=1 → gap_cnt=0, byte counted as in RX, back to RX (or complete the frame, as in RX).
  - valid=0 → gap_cnt+1.
  - When gap_cnt reaches GAP_CYCLES: frame_done=1, frame_len_ok=0, frame_len=byte_cnt, frame_chk=partial sum; out_eof is not asserted; go to IDLE.
- Back-to-back frames: a byte arriving the cycle after an EOF byte starts a new frame, with out_sof=1 in the cycle after out_eof.
- Good frame: frame_len_ok=1 and chk_err=0. good_cnt increments on the frame_done of a good frame; bad_cnt increments on any other frame_done.
- Counters hold at 2^CNT_W-1 once reached.
- Checksum: 16-bit unsigned add of zero-extended bytes; wraps with no carry-out.

Optional Feature:
- Macro CDC_PKT_DELIN_CHK_EN.
- Defined: on frame_done, chk_err = (frame_chk != EXP_CHK), and a mismatch counts the frame as bad.
- Undefined: chk_err is tied to 0 and no comparator is built; frame_chk is still reported.

Decomposition:
- Package cdc_pkt_pkg holds:
  - state enum {DLN_IDLE_S, DLN_RX_S, DLN_GAP_S};
  - CHK_W=16;
  - LEN_W=8;
  - default FRAME_BYTES=42.
- Sub-module cdc_sat_counter (parameter CNT_W; inputs clk_b, rst, inc; output count) is instantiated twice, for good_cnt and bad_cnt.

Test Plan:
1. One contiguous 42-byte frame 0x01..0x2A → out_sof with byte 0x01 and out_eof with byte 0x2A (each 1 cycle later); frame_done=1, frame_len=42, frame_len_ok=1, frame_chk=0x0387; good_cnt=1, bad_cnt=0.
2. Same frame with valid low for 3 cycles after byte 20 (GAP_CYCLES=4) → identical results to scenario 1; no early frame_done.
3. 20 bytes 0x01..0x14, then valid low → frame_done 1 cycle after the 4th idle cycle, frame_len=20, frame_len_ok=0, frame_chk=0x00D2, no out_eof; bad_cnt=1.
4. Two frames back-to-back with no idle cycle → out_eof in cycle N and out_sof in cycle N+1; two frame_done pulses; good_cnt=2.
5. rst=1 for one cycle at byte 10 of a frame, then a full frame → all outputs 0 after the reset edge and no frame_done for the partial frame; then good_cnt=1.
6. CNT_W=2, five good frames → good_cnt sequence 1,2,3,3,3. With CDC_PKT_DELIN_CHK_EN and EXP_CHK=0x0000, one frame gives chk_err=1 and bad_cnt=1.
